// File: rtl/sevenseg_scan_decoder.sv
// Recovers 4 digits from a multiplexed 7-seg scan: 2-flop sync, settle filter, slot-order FSM, commit 2 cycles after the slot-3 sample; no backpressure.
// Define SEG_ERR_CNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module sevenseg_scan_decoder #(
   parameter int SETTLE      = 4,
   parameter int TIMEOUT_CYC = 4_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] blank,
   output logic       frame_valid,
   output logic       err,
   output logic [7:0] err_cnt,
   output logic       stale
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [3:0]      an_m_q, an_m_d, an_s_q, an_s_d, an_p_q, an_p_d;
   logic [6:0]      seg_m_q, seg_m_d, seg_s_q, seg_s_d, seg_p_q, seg_p_d;
   logic [SW-1:0]   stab_q, stab_d;
   logic            sampled_q, sampled_d;
   logic [TW-1:0]   stale_cnt_q, stale_cnt_d;
   logic [1:0]      exp_q, exp_d;
   logic [3:0][3:0] stage_val_q, stage_val_d, digit_q, digit_d;
   logic [3:0]      stage_blk_q, stage_blk_d, blank_q, blank_d;
   logic            commit_q, commit_d, frame_valid_q, frame_valid_d, err_q, err_d;

   logic       in_chg, an_chg, settle_evt, one_hot, idle, sample, bad_an;
   logic [1:0] slot;
   logic       dec_ok, dec_blk;
   logic [3:0] dec_val;

   assign in_chg     = {an_s_q, seg_s_q} != {an_p_q, seg_p_q};
   assign an_chg     = an_s_q != an_p_q;
   assign idle       = an_s_q == 4'b1111;
   assign settle_evt = !in_chg && (stab_q == SW'(SETTLE - 1));
   assign sample     = settle_evt && one_hot && !sampled_q;
   assign bad_an     = settle_evt && !one_hot && !idle;

   always_comb begin
      slot    = 2'd0;
      one_hot = 1'b1;
      case (an_s_q)
         4'b1110: slot = 2'd0;
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         default: one_hot = 1'b0;
      endcase
      dec_ok  = 1'b1;
      dec_blk = 1'b0;
      dec_val = 4'd0;
      case (seg_s_q)
         7'h40: dec_val = 4'd0;
         7'h79: dec_val = 4'd1;
         7'h24: dec_val = 4'd2;
         7'h30: dec_val = 4'd3;
         7'h19: dec_val = 4'd4;
         7'h12: dec_val = 4'd5;
         7'h02: dec_val = 4'd6;
         7'h78: dec_val = 4'd7;
         7'h00: dec_val = 4'd8;
         7'h10: dec_val = 4'd9;
         7'h7F: dec_blk = 1'b1;
         default: begin
            dec_ok  = 1'b0;
            dec_val = 4'hF;
         end
      endcase
   end

   always_comb begin
      an_m_d  = an;
      an_s_d  = an_m_q;
      an_p_d  = an_s_q;
      seg_m_d = seg;
      seg_s_d = seg_m_q;
      seg_p_d = seg_s_q;

      if (in_chg)                      stab_d = '0;
      else if (stab_q != SW'(SETTLE))  stab_d = stab_q + SW'(1);
      else                             stab_d = stab_q;

      sampled_d = an_chg ? 1'b0 : (sampled_q | sample);

      if (an_chg)                              stale_cnt_d = '0;
      else if (stale_cnt_q != TW'(TIMEOUT_CYC)) stale_cnt_d = stale_cnt_q + TW'(1);
      else                                     stale_cnt_d = stale_cnt_q;

      // Staging lands one edge before the copy, so digits only ever move as a full frame.
      digit_d       = commit_q ? stage_val_q : digit_q;
      blank_d       = commit_q ? stage_blk_q : blank_q;
      frame_valid_d = commit_q;
   end

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      stage_val_d = stage_val_q;
      stage_blk_d = stage_blk_q;
      commit_d    = 1'b0;
      err_d       = 1'b0;
      if (state_q == HUNT) begin
         if (sample && slot == 2'd0) begin
            if (!dec_ok) begin
               err_d = 1'b1;
            end else begin
               stage_val_d[0] = dec_val;
               stage_blk_d[0] = dec_blk;
               state_d        = TRACK;
               exp_d          = 2'd1;
            end
         end
      end else if (bad_an) begin
         err_d   = 1'b1;
         state_d = HUNT;
      end else if (sample) begin
         if (slot != exp_q) begin
            err_d = 1'b1;
            // An out-of-order slot 0 is still a valid frame start.
            if (slot == 2'd0 && dec_ok) begin
               stage_val_d[0] = dec_val;
               stage_blk_d[0] = dec_blk;
               exp_d          = 2'd1;
            end else begin
               state_d = HUNT;
            end
         end else if (!dec_ok) begin
            err_d   = 1'b1;
            state_d = HUNT;
         end else begin
            stage_val_d[slot] = dec_val;
            stage_blk_d[slot] = dec_blk;
            if (slot == 2'd3) begin
               commit_d = 1'b1;
               state_d  = HUNT;
            end else begin
               exp_d = exp_q + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         an_m_q        <= '0;
         an_s_q        <= '0;
         an_p_q        <= '0;
         seg_m_q       <= '0;
         seg_s_q       <= '0;
         seg_p_q       <= '0;
         stab_q        <= '0;
         sampled_q     <= 1'b0;
         stale_cnt_q   <= '0;
         exp_q         <= '0;
         stage_val_q   <= '0;
         stage_blk_q   <= '0;
         commit_q      <= 1'b0;
         digit_q       <= '0;
         blank_q       <= 4'b1111;
         frame_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         an_m_q        <= an_m_d;
         an_s_q        <= an_s_d;
         an_p_q        <= an_p_d;
         seg_m_q       <= seg_m_d;
         seg_s_q       <= seg_s_d;
         seg_p_q       <= seg_p_d;
         stab_q        <= stab_d;
         sampled_q     <= sampled_d;
         stale_cnt_q   <= stale_cnt_d;
         exp_q         <= exp_d;
         stage_val_q   <= stage_val_d;
         stage_blk_q   <= stage_blk_d;
         commit_q      <= commit_d;
         digit_q       <= digit_d;
         blank_q       <= blank_d;
         frame_valid_q <= frame_valid_d;
         err_q         <= err_d;
      end
   end

`ifdef SEG_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'h00;
`endif

   assign digit0      = digit_q[0];
   assign digit1      = digit_q[1];
   assign digit2      = digit_q[2];
   assign digit3      = digit_q[3];
   assign blank       = blank_q;
   assign frame_valid = frame_valid_q;
   assign err         = err_q;
   assign stale       = stale_cnt_q == TW'(TIMEOUT_CYC);

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: a run-level scan model predicts the ordered frame/err pulse stream and committed digits.
module tb_sevenseg_scan_decoder;

   localparam int SETTLE = 4;
   localparam int TOUT   = 100;

   localparam logic [6:0] PATS   [0:10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                             7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
   localparam logic [3:0] ONEHOT [0:3]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [3:0] BAD_AN [0:5]  = '{4'b0000, 4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b1000};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] an = 4'hF;
   logic [6:0] seg = 7'h7F;
   logic [3:0] digit0, digit1, digit2, digit3, blank;
   logic       frame_valid, err, stale;
   logic [7:0] err_cnt;
   logic [15:0] dig_all;

   always #5 clk = ~clk;

   assign dig_all = {digit3, digit2, digit1, digit0};

   sevenseg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT_CYC(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .blank(blank), .frame_valid(frame_valid), .err(err),
      .err_cnt(err_cnt), .stale(stale)
   );

   typedef struct {
      bit          is_frame;
      logic [15:0] d;
      logic [3:0]  b;
   } ev_t;

   ev_t         evq[$];
   int          checks = 0;
   int          fails = 0;
   int          m_state, m_exp, m_errs, frames_seen;
   int          m_dig [0:3];
   bit          m_blk [0:3];
   bit          m_sampled;
   logic [10:0] cur_val;
   int          cur_len;
   logic [15:0] c_d;
   logic [3:0]  c_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_decode(input logic [6:0] p);
      for (int i = 0; i < 11; i++) if (PATS[i] == p) return i;
      return -1;
   endfunction

   function automatic logic [7:0] exp_err_cnt();
`ifdef SEG_ERR_CNT_EN
      return (m_errs > 255) ? 8'hFF : 8'(m_errs);
`else
      return 8'h00;
`endif
   endfunction

   task automatic push_err();
      ev_t e;
      e.is_frame = 1'b0;
      e.d = '0;
      e.b = '0;
      evq.push_back(e);
   endtask

   task automatic stage(input int s, input int v);
      m_dig[s] = (v == 10) ? 0 : v;
      m_blk[s] = (v == 10);
   endtask

   task automatic model_sample(input int s, input logic [6:0] p);
      int v;
      ev_t e;
      v = model_decode(p);
      if (m_state == 0) begin
         if (s == 0) begin
            if (v < 0) push_err();
            else begin stage(0, v); m_state = 1; m_exp = 1; end
         end
      end else if (s != m_exp) begin
         push_err();
         if (s == 0 && v >= 0) begin stage(0, v); m_exp = 1; end
         else m_state = 0;
      end else if (v < 0) begin
         push_err();
         m_state = 0;
      end else begin
         stage(s, v);
         if (s == 3) begin
            e.is_frame = 1'b1;
            e.d = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
            e.b = {m_blk[3], m_blk[2], m_blk[1], m_blk[0]};
            evq.push_back(e);
            m_state = 0;
         end else m_exp++;
      end
   endtask

   // Drive one run of constant {an,seg}; a run earns one settle event once it lasts SETTLE+1 cycles.
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      int slot;
      an  = a;
      seg = s;
      if ({a, s} != cur_val) begin
         if (a != cur_val[10:7]) m_sampled = 1'b0;
         cur_val = {a, s};
         cur_len = 0;
      end
      if (cur_len < SETTLE + 1 && cur_len + n >= SETTLE + 1) begin
         slot = -1;
         for (int i = 0; i < 4; i++) if (ONEHOT[i] == a) slot = i;
         if (slot >= 0) begin
            if (!m_sampled) begin
               m_sampled = 1'b1;
               model_sample(slot, s);
            end
         end else if (a != 4'hF && m_state == 1) begin
            push_err();
            m_state = 0;
         end
      end
      cur_len += n;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
      hold(4'b1110, p0, 20);
      hold(4'b1101, p1, 20);
      hold(4'b1011, p2, 20);
      hold(4'b0111, p3, 20);
      hold(4'b1111, 7'h7F, 20);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      an = 4'hF;
      seg = 7'h7F;
      evq.delete();
      m_state = 0; m_exp = 0; m_errs = 0; m_sampled = 1'b0;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_blk[i] = 1'b0; end
      c_d = 16'h0000;
      c_b = 4'hF;
      cur_val = {4'hF, 7'h7F};
      cur_len = SETTLE + 1;
      #1;
      check({tag, "_digits"}, 32'(dig_all), 32'h0);
      check({tag, "_blank"}, 32'(blank), 32'hF);
      check({tag, "_pulses_stale"}, 32'({frame_valid, err, stale}), 32'h0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid) begin
            check("frame_valid_expected", 32'((evq.size() > 0 && evq[0].is_frame) ? 1 : 0), 32'd1);
            if (evq.size() > 0 && evq[0].is_frame) begin
               c_d = evq[0].d;
               c_b = evq[0].b;
               void'(evq.pop_front());
               frames_seen++;
            end
         end
         if (err) begin
            check("err_expected", 32'((evq.size() > 0 && !evq[0].is_frame) ? 1 : 0), 32'd1);
            if (evq.size() > 0 && !evq[0].is_frame) begin
               void'(evq.pop_front());
               m_errs++;
            end
         end
         check("committed_outputs", 32'({dig_all, blank}), 32'({c_d, c_b}));
         check("err_cnt_track", 32'(err_cnt), 32'(exp_err_cnt()));
      end
   end

   initial begin
      int f0, nxt;
      frames_seen = 0;
      do_reset("reset");

      // clean frame 0,1,2,3
      f0 = frames_seen;
      scan(7'h40, 7'h79, 7'h24, 7'h30);
      check("t1_digits", 32'(dig_all), 32'h3210);
      check("t1_blank", 32'(blank), 32'h0);
      check("t1_frames", 32'(frames_seen - f0), 32'd1);

      // blank slot 2
      scan(7'h40, 7'h79, 7'h7F, 7'h30);
      check("t2_digits", 32'(dig_all), 32'h3010);
      check("t2_blank", 32'(blank), 32'b0100);
      check("t2_no_err", 32'(m_errs), 32'd0);

      // skipped slot
      do_reset("reset_t3");
      scan(7'h40, 7'h79, 7'h24, 7'h30);
      hold(4'b1110, 7'h40, 20);
      hold(4'b1011, 7'h24, 20);
      hold(4'b1111, 7'h7F, 20);
      check("t3_digits_kept", 32'(dig_all), 32'h3210);
      check("t3_errs", 32'(m_errs), 32'd1);
`ifdef SEG_ERR_CNT_EN
      check("t3_err_cnt", 32'(err_cnt), 32'd1);
`else
      check("t3_err_cnt", 32'(err_cnt), 32'd0);
`endif

      // bad pattern, then recovery
      hold(4'b1110, 7'h40, 20);
      hold(4'b1101, 7'h55, 20);
      hold(4'b1111, 7'h7F, 20);
      check("t4_abort_kept", 32'(dig_all), 32'h3210);
      check("t4_errs", 32'(m_errs), 32'd2);
      scan(7'h19, 7'h12, 7'h02, 7'h78);
      check("t4_digits", 32'(dig_all), 32'h7654);

      // glitchy segments at slot 0
      f0 = frames_seen;
      for (int i = 0; i < 5; i++) hold(4'b1110, (i % 2 == 0) ? 7'h40 : 7'h79, 2);
      hold(4'b1110, 7'h12, 20);
      hold(4'b1101, 7'h79, 20);
      hold(4'b1011, 7'h24, 20);
      hold(4'b0111, 7'h30, 20);
      hold(4'b1111, 7'h7F, 20);
      check("t5_digits", 32'(dig_all), 32'h3215);
      check("t5_frames", 32'(frames_seen - f0), 32'd1);

      // stale timeout
      hold(4'b1101, 7'h79, 95);
      check("t6_not_stale_yet", 32'(stale), 32'd0);
      hold(4'b1101, 7'h79, 10);
      check("t6_stale", 32'(stale), 32'd1);
      hold(4'b1111, 7'h7F, 2);
      check("t6_stale_held", 32'(stale), 32'd1);
      hold(4'b1111, 7'h7F, 2);
      check("t6_stale_clear", 32'(stale), 32'd0);

      // reset mid-frame
      scan(7'h00, 7'h10, 7'h79, 7'h24);
      check("t7_pre_digits", 32'(dig_all), 32'h2198);
      hold(4'b1110, 7'h40, 20);
      hold(4'b1101, 7'h79, 20);
      check("t7_pending", 32'(evq.size()), 32'd0);
      do_reset("reset_mid");
      f0 = frames_seen;
      hold(4'b1011, 7'h24, 20);
      hold(4'b0111, 7'h30, 20);
      hold(4'b1111, 7'h7F, 20);
      check("t7_no_partial_commit", 32'(frames_seen - f0), 32'd0);
      scan(7'h78, 7'h00, 7'h10, 7'h40);
      check("t7_digits", 32'(dig_all), 32'h0987);

      // randomized scans
      nxt = 0;
      for (int i = 0; i < 300; i++) begin
         int r, len;
         logic [3:0] a;
         logic [6:0] s;
         r = $urandom_range(0, 99);
         if (r < 70) begin a = ONEHOT[nxt]; nxt = (nxt + 1) % 4; end
         else if (r < 85) a = ONEHOT[$urandom_range(0, 3)];
         else if (r < 93) a = 4'hF;
         else a = BAD_AN[$urandom_range(0, 5)];
         s = ($urandom_range(0, 99) < 88) ? PATS[$urandom_range(0, 10)] : 7'($urandom);
         len = $urandom_range(1, 22);
         hold(a, s, len);
      end
      hold(4'b1111, 7'h7F, 30);
      check("rand_pending", 32'(evq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
